// File: rtl/mem_wb_skid_stage.sv
// MEM/WB writeback register with a valid/ready handshake. A main and a skid entry
// absorb backpressure, so in_ready_o comes straight from a flop.
module mem_wb_skid_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic [DATA_W-1:0] ALUout_i,
    input  logic [DATA_W-1:0] Memout_i,
    input  logic [RD_W-1:0]   rd_addr_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic [DATA_W-1:0] ALUout_o,
    output logic [DATA_W-1:0] Memout_o,
    output logic [RD_W-1:0]   rd_addr_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              main_valid_q, main_valid_d;
    logic              main_regwrite_q, main_regwrite_d;
    logic              main_memtoreg_q, main_memtoreg_d;
    logic [DATA_W-1:0] main_alu_q, main_alu_d;
    logic [DATA_W-1:0] main_mem_q, main_mem_d;
    logic [RD_W-1:0]   main_rd_q, main_rd_d;

    logic              skid_valid_q, skid_valid_d;
    logic              skid_regwrite_q, skid_regwrite_d;
    logic              skid_memtoreg_q, skid_memtoreg_d;
    logic [DATA_W-1:0] skid_alu_q, skid_alu_d;
    logic [DATA_W-1:0] skid_mem_q, skid_mem_d;
    logic [RD_W-1:0]   skid_rd_q, skid_rd_d;

    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid_i & in_ready_q;
    assign out_xfer = main_valid_q & out_ready_i;

    always_comb begin
        main_valid_d    = main_valid_q;
        main_regwrite_d = main_regwrite_q;
        main_memtoreg_d = main_memtoreg_q;
        main_alu_d      = main_alu_q;
        main_mem_d      = main_mem_q;
        main_rd_d       = main_rd_q;
        skid_valid_d    = skid_valid_q;
        skid_regwrite_d = skid_regwrite_q;
        skid_memtoreg_d = skid_memtoreg_q;
        skid_alu_d      = skid_alu_q;
        skid_mem_d      = skid_mem_q;
        skid_rd_d       = skid_rd_q;
        stall_cnt_d     = stall_cnt_q;

        if (flush_i) begin
            // Payload is left stale; only the valid bits matter after a flush.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_xfer) begin
            if (skid_valid_q) begin
                main_valid_d    = 1'b1;
                main_regwrite_d = skid_regwrite_q;
                main_memtoreg_d = skid_memtoreg_q;
                main_alu_d      = skid_alu_q;
                main_mem_d      = skid_mem_q;
                main_rd_d       = skid_rd_q;
                skid_valid_d    = 1'b0;
            end else begin
                main_valid_d = in_xfer;
                if (in_xfer) begin
                    main_regwrite_d = RegWrite_i;
                    main_memtoreg_d = MemtoReg_i;
                    main_alu_d      = ALUout_i;
                    main_mem_d      = Memout_i;
                    main_rd_d       = rd_addr_i;
                end
            end
        end else if (in_xfer) begin
            skid_valid_d    = 1'b1;
            skid_regwrite_d = RegWrite_i;
            skid_memtoreg_d = MemtoReg_i;
            skid_alu_d      = ALUout_i;
            skid_mem_d      = Memout_i;
            skid_rd_d       = rd_addr_i;
        end

        in_ready_d = ~skid_valid_d;

        if (main_valid_q && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_valid_q    <= 1'b0;
            main_regwrite_q <= 1'b0;
            main_memtoreg_q <= 1'b0;
            main_alu_q      <= '0;
            main_mem_q      <= '0;
            main_rd_q       <= '0;
            skid_valid_q    <= 1'b0;
            skid_regwrite_q <= 1'b0;
            skid_memtoreg_q <= 1'b0;
            skid_alu_q      <= '0;
            skid_mem_q      <= '0;
            skid_rd_q       <= '0;
            in_ready_q      <= 1'b1;
            stall_cnt_q     <= '0;
        end else begin
            main_valid_q    <= main_valid_d;
            main_regwrite_q <= main_regwrite_d;
            main_memtoreg_q <= main_memtoreg_d;
            main_alu_q      <= main_alu_d;
            main_mem_q      <= main_mem_d;
            main_rd_q       <= main_rd_d;
            skid_valid_q    <= skid_valid_d;
            skid_regwrite_q <= skid_regwrite_d;
            skid_memtoreg_q <= skid_memtoreg_d;
            skid_alu_q      <= skid_alu_d;
            skid_mem_q      <= skid_mem_d;
            skid_rd_q       <= skid_rd_d;
            in_ready_q      <= in_ready_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    // Bubbles and flushed slots must never reach the register file.
    assign out_valid_o = main_valid_q;
    assign RegWrite_o  = main_regwrite_q & main_valid_q;
    assign MemtoReg_o  = main_memtoreg_q;
    assign ALUout_o    = main_alu_q;
    assign Memout_o    = main_mem_q;
    assign rd_addr_o   = main_rd_q;
    assign in_ready_o  = in_ready_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Directed and scoreboarded bench for mem_wb_skid_stage (CNT_W=4 so saturation is reachable).
module tb_mem_wb_skid_stage;

    localparam int DATA_W = 32;
    localparam int RD_W   = 5;
    localparam int CNT_W  = 4;

    logic              clk_i = 1'b0;
    logic              rst_i, flush_i, in_valid_i, in_ready_o;
    logic              RegWrite_i, MemtoReg_i;
    logic [DATA_W-1:0] ALUout_i, Memout_i;
    logic [RD_W-1:0]   rd_addr_i;
    logic              out_valid_o, out_ready_i, RegWrite_o, MemtoReg_o;
    logic [DATA_W-1:0] ALUout_o, Memout_o;
    logic [RD_W-1:0]   rd_addr_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    int checks = 0;
    int failures = 0;

    mem_wb_skid_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
        .ALUout_i(ALUout_i), .Memout_i(Memout_i), .rd_addr_i(rd_addr_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
        .ALUout_o(ALUout_o), .Memout_o(Memout_o), .rd_addr_o(rd_addr_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r,
                         input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem,
                         input logic [RD_W-1:0] rd);
        in_valid_i = v;
        RegWrite_i = rw;
        MemtoReg_i = m2r;
        ALUout_i   = alu;
        Memout_i   = mem;
        rd_addr_i  = rd;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        flush_i = 1'b0;
        out_ready_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    typedef logic [70:0] beat_t;
    beat_t sb[$];

    initial begin
        beat_t exp_b;
        beat_t got_b;
        int accepted;
        int cycles;
        logic [DATA_W-1:0] ra, rm;
        logic [RD_W-1:0] rr;
        logic rw, m2r;

        // Reset with a valid write beat held on the inputs
        rst_i = 1'b1;
        flush_i = 1'b0;
        out_ready_i = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'h5, 32'h6, 5'd7);
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        rst_i = 1'b0;
        tick();
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_regwrite", RegWrite_o, 1'b0);
        chk("rst_stall_cnt", stall_cnt_o, 4'd0);
        chk("rst_in_ready", in_ready_o, 1'b1);
        chk("rst_alu", ALUout_o, 32'h0);

        // Streaming, out_ready held high
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, i[0], 32'h11 * (i + 1), 32'h100 + i, 5'(i + 1));
            chk("stream_in_ready", in_ready_o, 1'b1);
            tick();
            chk("stream_valid", out_valid_o, 1'b1);
            chk("stream_alu", ALUout_o, 32'h11 * (i + 1));
            chk("stream_mem", Memout_o, 32'h100 + i);
            chk("stream_rd", rd_addr_o, 5'(i + 1));
            chk("stream_m2r", MemtoReg_o, i[0]);
            chk("stream_regwrite", RegWrite_o, 1'b1);
        end
        drive(1'b0, 1'b1, 1'b0, '0, '0, '0);
        chk("stream_in_ready_end", in_ready_o, 1'b1);
        tick();
        chk("stream_drained", out_valid_o, 1'b0);
        chk("stream_bubble_rw", RegWrite_o, 1'b0);
        chk("stream_no_stall", stall_cnt_o, 4'd0);

        // Backpressure: A held, B in skid
        do_reset();
        out_ready_i = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'hA, 32'hA0, 5'd10);
        tick();
        chk("bp_a_valid", out_valid_o, 1'b1);
        chk("bp_a_alu", ALUout_o, 32'hA);
        chk("bp_a_ready", in_ready_o, 1'b1);
        chk("bp_a_stall", stall_cnt_o, 4'd0);
        drive(1'b1, 1'b0, 1'b1, 32'hB, 32'hB0, 5'd11);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        chk("bp_b_alu_held", ALUout_o, 32'hA);
        chk("bp_b_ready", in_ready_o, 1'b0);
        chk("bp_b_stall", stall_cnt_o, 4'd1);
        tick();
        chk("bp_hold_alu", ALUout_o, 32'hA);
        chk("bp_hold_rd", rd_addr_o, 5'd10);
        chk("bp_hold_stall", stall_cnt_o, 4'd2);
        tick();
        chk("bp_hold_stall2", stall_cnt_o, 4'd3);
        out_ready_i = 1'b1;
        tick();
        chk("bp_b_out_alu", ALUout_o, 32'hB);
        chk("bp_b_out_rd", rd_addr_o, 5'd11);
        chk("bp_b_out_rw", RegWrite_o, 1'b0);
        chk("bp_b_out_m2r", MemtoReg_o, 1'b1);
        chk("bp_ready_back", in_ready_o, 1'b1);
        chk("bp_stall_frozen", stall_cnt_o, 4'd3);
        tick();
        chk("bp_empty", out_valid_o, 1'b0);

        // Flush with both entries full and a beat offered
        do_reset();
        out_ready_i = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h1A, 32'h0, 5'd1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h1B, 32'h0, 5'd2);
        tick();
        chk("fl_full_ready", in_ready_o, 1'b0);
        chk("fl_pre_stall", stall_cnt_o, 4'd1);
        flush_i = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h1C, 32'h0, 5'd3);
        tick();
        flush_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        chk("fl_valid", out_valid_o, 1'b0);
        chk("fl_regwrite", RegWrite_o, 1'b0);
        chk("fl_ready", in_ready_o, 1'b1);
        chk("fl_stall_kept", stall_cnt_o, 4'd2);
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_no_emit", out_valid_o, 1'b0);
        end
        // Flush drops an input that was actually accepted the same cycle
        drive(1'b1, 1'b1, 1'b0, 32'h2A, 32'h0, 5'd4);
        tick();
        flush_i = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h2B, 32'h0, 5'd5);
        tick();
        flush_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        chk("fl2_valid", out_valid_o, 1'b0);
        chk("fl2_regwrite", RegWrite_o, 1'b0);
        tick();
        chk("fl2_no_emit", out_valid_o, 1'b0);

        // Stall counter saturation
        do_reset();
        out_ready_i = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h55, 32'h0, 5'd9);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("sat_cnt", stall_cnt_o, (k > 15) ? 4'd15 : 4'(k));
        end
        chk("sat_alu_stable", ALUout_o, 32'h55);

        // Random valid/ready with scoreboard
        do_reset();
        tick();
        accepted = 0;
        cycles = 0;
        sb.delete();
        while (accepted < 1000 && cycles < 20000) begin
            ra = $urandom;
            rm = $urandom;
            rr = RD_W'($urandom);
            rw = 1'($urandom);
            m2r = 1'($urandom);
            drive(($urandom_range(0, 3) != 0), rw, m2r, ra, rm, rr);
            out_ready_i = ($urandom_range(0, 2) != 0);
            chk("rnd_out_valid", out_valid_o, (sb.size() > 0));
            chk("rnd_in_ready", in_ready_o, (sb.size() < 2));
            if (!out_valid_o) chk("rnd_bubble_rw", RegWrite_o, 1'b0);
            if (out_valid_o && out_ready_i) begin
                if (sb.size() == 0) begin
                    chk("rnd_extra_beat", 1'b1, 1'b0);
                end else begin
                    exp_b = sb.pop_front();
                    got_b = {RegWrite_o, MemtoReg_o, ALUout_o, Memout_o, rd_addr_o};
                    chk("rnd_beat", got_b, exp_b);
                end
            end
            if (in_valid_i && in_ready_o) begin
                sb.push_back({rw, m2r, ra, rm, rr});
                accepted++;
            end
            tick();
            cycles++;
        end
        chk("rnd_accept_bound", (accepted >= 1000), 1'b1);
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        cycles = 0;
        while (sb.size() > 0 && cycles < 10) begin
            if (out_valid_o) begin
                exp_b = sb.pop_front();
                got_b = {RegWrite_o, MemtoReg_o, ALUout_o, Memout_o, rd_addr_o};
                chk("drain_beat", got_b, exp_b);
            end
            tick();
            cycles++;
        end
        chk("drain_left", sb.size(), 0);
        chk("drain_valid", out_valid_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
